// File: rtl/alu_issue_unit.sv
// alu_issue_unit
// Issue stage in front of the 8-bit ALU. It accepts one instruction word over
// a valid/ready handshake and reads both operands from a local 4x8 register
// file. It then drives the registered operands and opcode to the ALU, captures
// the result and zero flag, and writes the result back to the register file.
// A host can preload registers through the load port and read any register
// through the debug read port.
//
// Ports:
//   clk, rst                     system clock, synchronous active-high reset
//   instr_valid/ready, instr     instruction handshake; [7:6] op, [5:4] rd,
//                                [3:2] rs1, [1:0] rs2
//   load_en/addr/data            host register write (IDLE only)
//   rd_addr, rd_data             combinational debug read of the register file
//   alu_in1/in2/opcode           registered operands and opcode to the ALU
//   alu_data, alu_flag           ALU result and flags (bit 0 = zero)
//   wb_valid/addr/data           write-back strobe, destination and result
//   zero_flag                    zero status of the last non-NOP instruction
//   busy                         high whenever the FSM is not in IDLE
//   retired_count                retired-instruction counter (ALU_ISSUE_CNT_EN)
//
// Build option: define ALU_ISSUE_CNT_EN to add the 16-bit retired_count output.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | ready for an instruction; host loads are accepted
// EXEC  | operands are on the ALU, result settles; sampled at exit
// WB    | wb_valid high; result committed to rd at exit (unless NOP)

module alu_issue_unit #(
   parameter int DW   = 8,
   parameter int NREG = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    instr_valid,
   output logic                    instr_ready,
   input  logic [7:0]              instr,
   input  logic                    load_en,
   input  logic [$clog2(NREG)-1:0] load_addr,
   input  logic [DW-1:0]           load_data,
   input  logic [$clog2(NREG)-1:0] rd_addr,
   output logic [DW-1:0]           rd_data,
   output logic [DW-1:0]           alu_in1,
   output logic [DW-1:0]           alu_in2,
   output logic [1:0]              alu_opcode,
   input  logic [DW-1:0]           alu_data,
   input  logic [7:0]              alu_flag,
   output logic                    wb_valid,
   output logic [$clog2(NREG)-1:0] wb_addr,
   output logic [DW-1:0]           wb_data,
   output logic                    zero_flag,
   output logic                    busy
`ifdef ALU_ISSUE_CNT_EN
   ,
   output logic [15:0]             retired_count
`endif
);

   localparam int AW = $clog2(NREG);
   localparam logic [1:0] OP_NOP = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_t;

   state_t                 state;
   logic [NREG-1:0][DW-1:0] regs;
   logic [1:0]             op_q;
   logic [AW-1:0]          rd_q;
   logic                   zero_q;

   logic [1:0]    i_op;
   logic [AW-1:0] i_rd;
   logic [AW-1:0] i_rs1;
   logic [AW-1:0] i_rs2;

   assign i_op  = instr[7:6];
   assign i_rd  = instr[5:4];
   assign i_rs1 = instr[3:2];
   assign i_rs2 = instr[1:0];

   // Only the zero bit of the ALU flag bus is meaningful here.
   logic unused_flag;
   assign unused_flag = ^alu_flag[7:1];

   assign instr_ready = (state == IDLE) && !rst;
   assign busy        = (state != IDLE);
   assign rd_data     = regs[rd_addr];

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         regs       <= '0;
         alu_in1    <= '0;
         alu_in2    <= '0;
         alu_opcode <= OP_NOP;
         op_q       <= OP_NOP;
         rd_q       <= '0;
         zero_q     <= 1'b0;
         wb_valid   <= 1'b0;
         wb_addr    <= '0;
         wb_data    <= '0;
         zero_flag  <= 1'b0;
`ifdef ALU_ISSUE_CNT_EN
         retired_count <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               // Operands read the pre-edge register values, so a load on the
               // same edge is not forwarded.
               if (load_en)
                  regs[load_addr] <= load_data;
               if (instr_valid) begin
                  alu_in1    <= regs[i_rs1];
                  alu_in2    <= regs[i_rs2];
                  alu_opcode <= i_op;
                  op_q       <= i_op;
                  rd_q       <= i_rd;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               wb_data  <= alu_data;
               wb_addr  <= rd_q;
               zero_q   <= alu_flag[0];
               wb_valid <= 1'b1;
               state    <= WB;
            end
            WB: begin
               wb_valid <= 1'b0;
               if (op_q != OP_NOP) begin
                  regs[rd_q] <= wb_data;
                  zero_flag  <= zero_q;
               end
`ifdef ALU_ISSUE_CNT_EN
               retired_count <= retired_count + 16'd1;
`endif
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit
// Directed bench for alu_issue_unit. A small behavioural ALU (ADD/SUB/MUL,
// op 3 outputs 0x00 with zero set) sits on the ALU side. Each task drives one
// scenario and compares outputs against hand-computed values. Outputs are
// sampled 1 ns after the rising edge.

module tb_alu_issue_unit;

   logic       clk;
   logic       rst;
   logic       instr_valid;
   logic       instr_ready;
   logic [7:0] instr;
   logic       load_en;
   logic [1:0] load_addr;
   logic [7:0] load_data;
   logic [1:0] rd_addr;
   logic [7:0] rd_data;
   logic [7:0] alu_in1;
   logic [7:0] alu_in2;
   logic [1:0] alu_opcode;
   logic [7:0] alu_data;
   logic [7:0] alu_flag;
   logic       wb_valid;
   logic [1:0] wb_addr;
   logic [7:0] wb_data;
   logic       zero_flag;
   logic       busy;
`ifdef ALU_ISSUE_CNT_EN
   logic [15:0] retired_count;
`endif

   int errors = 0;
   int checks = 0;

   alu_issue_unit dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .load_en     (load_en),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .alu_in1     (alu_in1),
      .alu_in2     (alu_in2),
      .alu_opcode  (alu_opcode),
      .alu_data    (alu_data),
      .alu_flag    (alu_flag),
      .wb_valid    (wb_valid),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .zero_flag   (zero_flag),
      .busy        (busy)
`ifdef ALU_ISSUE_CNT_EN
      ,
      .retired_count (retired_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      alu_data = 8'h00;
      case (alu_opcode)
         2'd0: alu_data = alu_in1 + alu_in2;
         2'd1: alu_data = alu_in1 - alu_in2;
         2'd2: alu_data = alu_in1 * alu_in2;
         default: alu_data = 8'h00;
      endcase
      alu_flag = {7'b0, (alu_data == 8'h00)};
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [1:0] a, input logic [7:0] d);
      load_addr = a;
      load_data = d;
      load_en   = 1'b1;
      tick();
      load_en   = 1'b0;
   endtask

   task automatic check_reg(input string name, input logic [1:0] a, input logic [7:0] exp);
      rd_addr = a;
      #1;
      checks++;
      if (rd_data !== exp) begin
         errors++;
         $display("FAIL %s r%0d: got %h expected %h", name, a, rd_data, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      checks++;
      if (instr_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset ready_in_rst: got %b expected 0", instr_ready);
      end
      tick();
      rst = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) check_reg("reset", 2'(i), 8'h00);
      checks++;
      if (instr_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset ready: got %b expected 1", instr_ready);
      end
      checks++;
      if (alu_opcode !== 2'd3 || alu_in1 !== 8'h00 || alu_in2 !== 8'h00) begin
         errors++;
         $display("FAIL reset alu_out: got op=%0d in1=%h in2=%h expected op=3 in1=00 in2=00",
                  alu_opcode, alu_in1, alu_in2);
      end
      checks++;
      if (wb_valid !== 1'b0 || wb_data !== 8'h00 || zero_flag !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset status: got wbv=%b wbd=%h z=%b busy=%b expected 0 00 0 0",
                  wb_valid, wb_data, zero_flag, busy);
      end
`ifdef ALU_ISSUE_CNT_EN
      checks++;
      if (retired_count !== 16'd0) begin
         errors++;
         $display("FAIL reset retired: got %0d expected 0", retired_count);
      end
`endif
   endtask

   // Full issue of one instruction: operand, write-back and commit checks.
   task automatic run_op(input string name, input logic [7:0] ins,
                         input logic [7:0] e1, input logic [7:0] e2,
                         input logic [7:0] ewb, input logic [7:0] ereg, input logic ez);
      instr       = ins;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      checks++;
      if (alu_in1 !== e1 || alu_in2 !== e2 || alu_opcode !== ins[7:6] || busy !== 1'b1) begin
         errors++;
         $display("FAIL %s operands: got in1=%h in2=%h op=%0d busy=%b expected %h %h %0d 1",
                  name, alu_in1, alu_in2, alu_opcode, busy, e1, e2, ins[7:6]);
      end
      checks++;
      if (wb_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s wb_early: got %b expected 0", name, wb_valid);
      end
      tick();
      checks++;
      if (wb_valid !== 1'b1 || wb_data !== ewb || wb_addr !== ins[5:4]) begin
         errors++;
         $display("FAIL %s wb: got v=%b d=%h a=%0d expected 1 %h %0d",
                  name, wb_valid, wb_data, wb_addr, ewb, ins[5:4]);
      end
      tick();
      checks++;
      if (wb_valid !== 1'b0 || busy !== 1'b0 || zero_flag !== ez) begin
         errors++;
         $display("FAIL %s post: got wbv=%b busy=%b z=%b expected 0 0 %b",
                  name, wb_valid, busy, zero_flag, ez);
      end
      check_reg(name, ins[5:4], ereg);
   endtask

   task automatic test_basic_ops();
      load(2'd1, 8'h05);
      load(2'd2, 8'h03);
      run_op("add", 8'h06, 8'h05, 8'h03, 8'h08, 8'h08, 1'b0);
      run_op("sub", 8'h75, 8'h05, 8'h05, 8'h00, 8'h00, 1'b1);
      run_op("mul", 8'h86, 8'h05, 8'h03, 8'h0F, 8'h0F, 1'b0);
      // NOP: ALU model reports zero, but neither r0 nor zero_flag may change.
      run_op("nop", 8'hC6, 8'h05, 8'h03, 8'h00, 8'h0F, 1'b0);
      tick();
      tick();
      checks++;
      if (alu_in1 !== 8'h05 || alu_opcode !== 2'd3 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_hold: got in1=%h op=%0d busy=%b expected 05 3 0",
                  alu_in1, alu_opcode, busy);
      end
   endtask

   task automatic test_overflow();
      load(2'd1, 8'h10);
      load(2'd2, 8'h10);
      run_op("mul_ovf", 8'h86, 8'h10, 8'h10, 8'h00, 8'h00, 1'b1);
      load(2'd1, 8'h80);
      load(2'd2, 8'h80);
      run_op("add_80", 8'h06, 8'h80, 8'h80, 8'h00, 8'h00, 1'b1);
      load(2'd1, 8'hFF);
      load(2'd2, 8'h01);
      run_op("add_ff", 8'h06, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1);
   endtask

   task automatic test_back_to_back();
      int acc[3];
      int n = 0;
      load(2'd1, 8'h01);
      load(2'd3, 8'h00);
      instr       = 8'h3D;
      instr_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (instr_valid && instr_ready) begin
            acc[n] = i;
            n++;
         end
         // Cycle 4 is the EXEC cycle of the second instruction.
         if (i == 4) begin
            load_addr = 2'd1;
            load_data = 8'h40;
            load_en   = 1'b1;
         end
         tick();
         load_en = 1'b0;
         if (n == 3) instr_valid = 1'b0;
      end
      instr_valid = 1'b0;
      checks++;
      if (n !== 3) begin
         errors++;
         $display("FAIL b2b accepts: got %0d expected 3", n);
      end else begin
         checks++;
         if (acc[0] !== 0 || acc[1] !== 3 || acc[2] !== 6) begin
            errors++;
            $display("FAIL b2b spacing: got %0d %0d %0d expected 0 3 6", acc[0], acc[1], acc[2]);
         end
      end
      check_reg("b2b", 2'd3, 8'h03);
      check_reg("load_dropped", 2'd1, 8'h01);
   endtask

   task automatic test_load_same_edge();
      load_addr   = 2'd1;
      load_data   = 8'h20;
      load_en     = 1'b1;
      instr       = 8'h06;
      instr_valid = 1'b1;
      tick();
      load_en     = 1'b0;
      instr_valid = 1'b0;
      checks++;
      if (alu_in1 !== 8'h01 || alu_in2 !== 8'h01) begin
         errors++;
         $display("FAIL same_edge operand: got in1=%h in2=%h expected 01 01", alu_in1, alu_in2);
      end
      tick();
      tick();
      check_reg("same_edge_load", 2'd1, 8'h20);
      check_reg("same_edge_result", 2'd0, 8'h02);
   endtask

   task automatic test_reset_abort();
      instr       = 8'h06;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL abort in_exec: got busy=%b expected 1", busy);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (wb_valid !== 1'b0 || busy !== 1'b0 || alu_opcode !== 2'd3 || zero_flag !== 1'b0) begin
         errors++;
         $display("FAIL abort state: got wbv=%b busy=%b op=%0d z=%b expected 0 0 3 0",
                  wb_valid, busy, alu_opcode, zero_flag);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (wb_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort no_wb: got %b expected 0", wb_valid);
      end
      check_reg("abort", 2'd0, 8'h00);
`ifdef ALU_ISSUE_CNT_EN
      checks++;
      if (retired_count !== 16'd0) begin
         errors++;
         $display("FAIL abort retired: got %0d expected 0", retired_count);
      end
      load(2'd1, 8'h02);
      load(2'd2, 8'h03);
      run_op("cnt_add", 8'h06, 8'h02, 8'h03, 8'h05, 8'h05, 1'b0);
      run_op("cnt_mul", 8'h86, 8'h02, 8'h03, 8'h06, 8'h06, 1'b0);
      run_op("cnt_nop", 8'hC6, 8'h02, 8'h03, 8'h00, 8'h06, 1'b0);
      checks++;
      if (retired_count !== 16'd3) begin
         errors++;
         $display("FAIL retired_count: got %0d expected 3", retired_count);
      end
`endif
   endtask

   initial begin
      rst         = 1'b1;
      instr_valid = 1'b0;
      instr       = 8'h00;
      load_en     = 1'b0;
      load_addr   = 2'd0;
      load_data   = 8'h00;
      rd_addr     = 2'd0;
      test_reset();
      test_basic_ops();
      test_overflow();
      test_back_to_back();
      test_load_same_edge();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
